// File: rtl/output_lif_integrator_pkg.sv
// Shared encodings for the output-layer LIF integrator.
// Optional build macro: LIF_LEAK_EN (adds the membrane leak term).
package snn_out_pkg;

    typedef enum logic [1:0] {
        SYS_IDLE     = 2'b00,
        SYS_SAMPLE   = 2'b01,
        SYS_COMPLETE = 2'b10,
        SYS_UART     = 2'b11
    } sys_state_e;

    localparam int NUM_CLASSES = 4;
    localparam int CLS_H = 0;
    localparam int CLS_U = 1;
    localparam int CLS_S = 2;
    localparam int CLS_T = 3;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10,
        ST_INTEG = 2'b11
    } lif_state_e;

endpackage

// File: rtl/output_lif_integrator_if.sv
// Timestep handshake, weight ROM port and class potential outputs.
interface output_lif_integrator_if #(
    parameter int N_IN   = 64,
    parameter int W_BITS = 4
);
    localparam int A_BITS = $clog2(N_IN);

    logic [1:0]          system_state;
    logic                step_valid;
    logic                step_ready;
    logic [N_IN-1:0]     spike_in;
    logic [A_BITS-1:0]   weight_addr;
    logic [4*W_BITS-1:0] weight_data;
    logic                step_done;
    logic [2:0]          potential1_h, potential1_u, potential1_s, potential1_t;
    logic [2:0]          potential2_h, potential2_u, potential2_s, potential2_t;

    modport master (
        output system_state, step_valid, spike_in, weight_data,
        input  step_ready, weight_addr, step_done,
        input  potential1_h, potential1_u, potential1_s, potential1_t,
        input  potential2_h, potential2_u, potential2_s, potential2_t
    );

    modport slave (
        input  system_state, step_valid, spike_in, weight_data,
        output step_ready, weight_addr, step_done,
        output potential1_h, potential1_u, potential1_s, potential1_t,
        output potential2_h, potential2_u, potential2_s, potential2_t
    );

endinterface

// File: rtl/output_lif_integrator_lane.sv
// One output class: weight-sum accumulator, membrane, fire counter, level quantiser.
// Optional build macro: LIF_LEAK_EN (subtract V >>> LEAK_SHIFT each timestep).
module output_lif_lane #(
    parameter int W_BITS     = 4,
    parameter int V_BITS     = 12,
    parameter int SUM_BITS   = 11,
    parameter int THRESH     = 256,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_sum,
    input  logic                     acc_en,
    input  logic signed [W_BITS-1:0] weight,
    input  logic                     integ,
    input  logic                     abort,
    output logic [2:0]               count,
    output logic [2:0]               level
);
`ifdef LIF_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif
    localparam int EXT     = ((V_BITS > SUM_BITS) ? V_BITS : SUM_BITS) + 2;
    localparam int Q_SHIFT = $clog2(THRESH) - 3;
    localparam logic signed [EXT-1:0]    V_MAX = EXT'(2**(V_BITS-1) - 1);
    localparam logic signed [EXT-1:0]    V_MIN = -V_MAX - EXT'(1);
    localparam logic signed [V_BITS-1:0] THR   = V_BITS'(THRESH);

    logic signed [SUM_BITS-1:0] sum;
    logic signed [V_BITS-1:0]   v, v_new, leak;
    logic signed [EXT-1:0]      v_ext;
    logic                       fire;
    logic [2:0]                 level_new;

    // Candidate membrane value, fire decision and quantised level for this step.
    always_comb begin
        leak  = LEAK_ON ? (v >>> LEAK_SHIFT) : '0;
        v_ext = EXT'(v) - EXT'(leak) + EXT'(sum);
        if (v_ext > V_MAX) begin
            v_new = V_MAX[V_BITS-1:0];
        end else if (v_ext < V_MIN) begin
            v_new = V_MIN[V_BITS-1:0];
        end else begin
            v_new = v_ext[V_BITS-1:0];
        end
        fire = (v_new >= THR);
        if (v_new[V_BITS-1] || (v_new == '0)) begin
            level_new = 3'd0;
        end else if (v_new >= THR) begin
            level_new = 3'd7;
        end else begin
            level_new = v_new[Q_SHIFT+2:Q_SHIFT];
        end
    end

    // Accumulate, integrate and fire; an IDLE abort wipes the class state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            v     <= '0;
            count <= 3'd0;
            level <= 3'd0;
        end else if (abort) begin
            sum   <= '0;
            v     <= '0;
            count <= 3'd0;
            level <= 3'd0;
        end else begin
            if (clear_sum) begin
                sum <= '0;
            end else if (acc_en) begin
                sum <= sum + SUM_BITS'(weight);
            end
            if (integ) begin
                if (fire) begin
                    v     <= '0;
                    count <= (count == 3'd7) ? 3'd7 : count + 3'd1;
                    level <= 3'd0;
                end else begin
                    v     <= v_new;
                    level <= level_new;
                end
            end
        end
    end

endmodule

// File: rtl/output_lif_integrator.sv
// Output-layer LIF stage: shared controller plus four class lanes (h,u,s,t).
// Optional build macro: LIF_LEAK_EN (enables membrane leak in every lane).
module output_lif_integrator
    import snn_out_pkg::*;
#(
    parameter int N_IN       = 64,
    parameter int W_BITS     = 4,
    parameter int V_BITS     = 12,
    parameter int THRESH     = 256,
    parameter int LEAK_SHIFT = 4
) (
    input  logic clk,
    input  logic rst,
    output_lif_integrator_if.slave bus
);
    localparam int A_BITS   = $clog2(N_IN);
    localparam int SUM_BITS = W_BITS + A_BITS + 1;

    lif_state_e        state, state_nxt;
    logic [N_IN-1:0]   spikes;
    logic [A_BITS-1:0] addr, acc_idx;
    logic              acc_valid, acc_en;
    logic              sys_idle, sys_sample, accept, integ, step_done;
    logic [2:0]        p1 [NUM_CLASSES];
    logic [2:0]        p2 [NUM_CLASSES];

    assign sys_idle       = (bus.system_state == SYS_IDLE);
    assign sys_sample     = (bus.system_state == SYS_SAMPLE);
    // Ready is masked by rst so nothing can be accepted while reset is held.
    assign bus.step_ready = (state == ST_WAIT) && sys_sample && !rst;
    assign accept         = bus.step_ready && bus.step_valid;
    assign integ          = (state == ST_INTEG) && !sys_idle;
    assign acc_en         = acc_valid && spikes[acc_idx];

    // Step sequencing; IDLE forces a return to WAIT from any state.
    always_comb begin
        state_nxt = state;
        if (sys_idle) begin
            state_nxt = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT:  if (accept) state_nxt = ST_FETCH;
                ST_FETCH: if (addr == A_BITS'(N_IN - 1)) state_nxt = ST_DRAIN;
                ST_DRAIN: state_nxt = ST_INTEG;
                ST_INTEG: state_nxt = ST_WAIT;
                default:  state_nxt = ST_WAIT;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_WAIT;
        else     state <= state_nxt;
    end

    // Spike latch, ROM address walk, one-cycle ROM delay tracking, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spikes    <= '0;
            addr      <= '0;
            acc_idx   <= '0;
            acc_valid <= 1'b0;
            step_done <= 1'b0;
        end else begin
            step_done <= integ;
            acc_valid <= (state == ST_FETCH) && !sys_idle;
            acc_idx   <= addr;
            if (accept) spikes <= bus.spike_in;
            if ((state == ST_FETCH) && (state_nxt == ST_FETCH)) addr <= addr + A_BITS'(1);
            else                                                 addr <= '0;
        end
    end

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
        output_lif_lane #(
            .W_BITS(W_BITS), .V_BITS(V_BITS), .SUM_BITS(SUM_BITS),
            .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .clear_sum(accept),
            .acc_en(acc_en),
            .weight(bus.weight_data[(NUM_CLASSES-c)*W_BITS-1 -: W_BITS]),
            .integ(integ),
            .abort(sys_idle),
            .count(p1[c]),
            .level(p2[c])
        );
    end

    assign bus.weight_addr  = addr;
    assign bus.step_done    = step_done;
    assign bus.potential1_h = p1[CLS_H];
    assign bus.potential1_u = p1[CLS_U];
    assign bus.potential1_s = p1[CLS_S];
    assign bus.potential1_t = p1[CLS_T];
    assign bus.potential2_h = p2[CLS_H];
    assign bus.potential2_u = p2[CLS_U];
    assign bus.potential2_s = p2[CLS_S];
    assign bus.potential2_t = p2[CLS_T];

endmodule

// File: tb/tb_output_lif_integrator.sv
// Directed bench for output_lif_integrator with a registered weight ROM model.
module tb_output_lif_integrator;
    import snn_out_pkg::*;

    localparam int N_IN   = 64;
    localparam int W_BITS = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [4*W_BITS-1:0] rom [N_IN];

    output_lif_integrator_if #(.N_IN(N_IN), .W_BITS(W_BITS)) bus ();

    output_lif_integrator #(
        .N_IN(N_IN), .W_BITS(W_BITS), .V_BITS(12), .THRESH(256), .LEAK_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.weight_data <= rom[bus.weight_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pots(input string tag,
                              input logic [2:0] h1, input logic [2:0] u1,
                              input logic [2:0] s1, input logic [2:0] t1,
                              input logic [2:0] h2, input logic [2:0] u2,
                              input logic [2:0] s2, input logic [2:0] t2);
        check({tag, ".p1_h"}, 32'(bus.potential1_h), 32'(h1));
        check({tag, ".p1_u"}, 32'(bus.potential1_u), 32'(u1));
        check({tag, ".p1_s"}, 32'(bus.potential1_s), 32'(s1));
        check({tag, ".p1_t"}, 32'(bus.potential1_t), 32'(t1));
        check({tag, ".p2_h"}, 32'(bus.potential2_h), 32'(h2));
        check({tag, ".p2_u"}, 32'(bus.potential2_u), 32'(u2));
        check({tag, ".p2_s"}, 32'(bus.potential2_s), 32'(s2));
        check({tag, ".p2_t"}, 32'(bus.potential2_t), 32'(t2));
    endtask

    task automatic load_rom(input logic [3:0] wh, input logic [3:0] wu,
                            input logic [3:0] ws, input logic [3:0] wt);
        for (int i = 0; i < N_IN; i++) rom[i] = {wh, wu, ws, wt};
    endtask

    // Handshake one timestep and wait (bounded) for step_done.
    // lat = cycles from the handshake edge to step_done, 0 if it never came.
    task automatic run_step(input logic [N_IN-1:0] sp, input int sw_at, input logic [1:0] sw_to,
                            output int lat, output int addr10, output int rdy10);
        @(negedge clk);
        bus.step_valid = 1'b1;
        bus.spike_in   = sp;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        lat    = 0;
        addr10 = -1;
        rdy10  = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == sw_at) bus.system_state = sw_to;
            @(posedge clk);
            #1;
            if (n == 10) begin
                addr10 = int'(bus.weight_addr);
                rdy10  = int'(bus.step_ready);
            end
            if (bus.step_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_pulse(input string tag);
        @(posedge clk);
        #1;
        check(tag, 32'(bus.step_done), 32'd0);
    endtask

    initial begin
        int lat, a10, r10, cnt;
        logic [N_IN-1:0] all_ones;
        logic [N_IN-1:0] low_half;
        all_ones = '1;
        low_half = {32'h0, 32'hFFFF_FFFF};

        rst              = 1'b1;
        bus.system_state = SYS_SAMPLE;
        bus.step_valid   = 1'b0;
        bus.spike_in     = '0;
        load_rom(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.step_ready), 32'd0);
        check("rst_done", 32'(bus.step_done), 32'd0);
        check("rst_addr", 32'(bus.weight_addr), 32'd0);
        check_pots("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_sample", 32'(bus.step_ready), 32'd1);

        // h +4, u +1, s -8, t +2 on every synapse, all spikes set
        load_rom(4'd4, 4'd1, 4'b1000, 4'd2);
        run_step(all_ones, 0, SYS_SAMPLE, lat, a10, r10);
        check("A1.latency", 32'(lat), 32'd66);
        check("A1.addr10", 32'(a10), 32'd10);
        check("A1.ready_busy", 32'(r10), 32'd0);
        check_pulse("A1.done_pulse");
        check_pots("A1", 1, 0, 0, 0, 0, 2, 0, 4);
        for (int s = 2; s <= 7; s++) begin
            run_step(all_ones, 0, SYS_SAMPLE, lat, a10, r10);
            check_pulse("A.done_pulse");
        end
        check("A7.latency", 32'(lat), 32'd66);
        check("A7.p1_h", 32'(bus.potential1_h), 32'd7);
        run_step(all_ones, 0, SYS_SAMPLE, lat, a10, r10);
        check_pulse("A8.done_pulse");
        run_step(all_ones, 0, SYS_SAMPLE, lat, a10, r10);
        check_pulse("A9.done_pulse");
`ifdef LIF_LEAK_EN
        check_pots("A9", 7, 1, 0, 3, 0, 7, 0, 0);
`else
        check_pots("A9", 7, 2, 0, 4, 0, 2, 0, 4);
`endif

        @(negedge clk);
        bus.system_state = SYS_IDLE;
        @(posedge clk);
        #1;
        check("idle_ready", 32'(bus.step_ready), 32'd0);
        check_pots("idle_clear", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.system_state = SYS_SAMPLE;

        // h +1, u -1, s +7, t -8, lower 32 spikes; COMPLETE arrives mid-step
        load_rom(4'd1, 4'hF, 4'd7, 4'b1000);
        run_step(low_half, 10, SYS_COMPLETE, lat, a10, r10);
        check("B1.latency", 32'(lat), 32'd66);
        check_pulse("B1.done_pulse");
        check("B1.ready_complete", 32'(bus.step_ready), 32'd0);
        check_pots("B1", 0, 0, 0, 0, 1, 0, 7, 0);

        bus.step_valid = 1'b1;
        bus.spike_in   = all_ones;
        cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (bus.step_done || (bus.weight_addr != '0) || bus.step_ready) cnt++;
        end
        bus.step_valid = 1'b0;
        check("complete_no_accept", 32'(cnt), 32'd0);
        check_pots("B1.hold", 0, 0, 0, 0, 1, 0, 7, 0);

        @(negedge clk);
        bus.system_state = SYS_SAMPLE;
        run_step(low_half, 0, SYS_SAMPLE, lat, a10, r10);
        check("B2.latency", 32'(lat), 32'd66);
        check_pulse("B2.done_pulse");
`ifdef LIF_LEAK_EN
        check_pots("B2", 0, 0, 1, 0, 1, 0, 0, 0);
`else
        check_pots("B2", 0, 0, 1, 0, 2, 0, 0, 0);
`endif

        @(negedge clk);
        bus.system_state = SYS_COMPLETE;
        repeat (3) @(posedge clk);
        #1;
        check("complete_hold.p1_s", 32'(bus.potential1_s), 32'd1);
        @(negedge clk);
        bus.system_state = SYS_IDLE;
        @(posedge clk);
        #1;
        check("complete_idle.p1_s", 32'(bus.potential1_s), 32'd0);
        check("complete_idle.p2_h", 32'(bus.potential2_h), 32'd0);

        // IDLE in the middle of FETCH: the step is dropped without step_done
        @(negedge clk);
        bus.system_state = SYS_SAMPLE;
        load_rom(4'd4, 4'd1, 4'b1000, 4'd2);
        run_step(all_ones, 20, SYS_IDLE, lat, a10, r10);
        check("abort.no_done", 32'(lat), 32'd0);
        check_pots("abort", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.system_state = SYS_SAMPLE;
        #1;
        check("abort.ready_again", 32'(bus.step_ready), 32'd1);

        // Reset in the middle of FETCH after one completed step
        run_step(all_ones, 0, SYS_SAMPLE, lat, a10, r10);
        check("C1.latency", 32'(lat), 32'd66);
        check("C1.p1_h", 32'(bus.potential1_h), 32'd1);
        check_pulse("C1.done_pulse");
        @(negedge clk);
        bus.step_valid = 1'b1;
        bus.spike_in   = all_ones;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid.addr", 32'(bus.weight_addr), 32'd0);
        check("rstmid.ready", 32'(bus.step_ready), 32'd0);
        check("rstmid.done", 32'(bus.step_done), 32'd0);
        check_pots("rstmid", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rstmid.ready_held", 32'(bus.step_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.ready_after", 32'(bus.step_ready), 32'd1);
        cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (bus.step_done) cnt++;
        end
        check("rstmid.no_done", 32'(cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
